// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 key schedule.
// Holds the S-box, the round constants and the FSM state encoding.
package aes_pkg;

  localparam int NR       = 10;
  localparam int NK_WORDS = 4;

  // Forward S-box, entry b is S(b).
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round constants; valid for rounds 1..10, zero elsewhere.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    FINISH = 2'd2
  } state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key expansion step, purely combinational.
// Four S-box lookups on the rotated last word, then a word XOR chain.
module aes_key_round
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [3:0]   round,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  assign sub[31:24] = sbox(rot[31:24]);
  assign sub[23:16] = sbox(rot[23:16]);
  assign sub[15:8]  = sbox(rot[15:8]);
  assign sub[7:0]   = sbox(rot[7:0]);

  assign t  = sub ^ {RCON[round], 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion: one round key per clock.
// Stores rk[0..10] and serves them through a combinational read port.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         valid_q, valid_d;
  logic         load;
  logic         wr;
  logic [127:0] rk_q [0:NR];
  logic [3:0]   src_idx;
  logic [127:0] prev_key;
  logic [127:0] next_key;

  assign src_idx  = round_q - 4'd1;
  assign prev_key = (src_idx <= 4'(NR)) ? rk_q[src_idx] : '0;

  aes_key_round u_round (
    .prev_key (prev_key),
    .round    (round_q),
    .next_key (next_key)
  );

  // Next-state, counter and handshake flag decode.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = done_q;
    valid_d = valid_q;
    load    = 1'b0;
    wr      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXPAND;
          round_d = 4'd1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          load    = 1'b1;
        end
      end
      EXPAND: begin
        wr      = 1'b1;
        round_d = round_q + 4'd1;
        if (round_q == 4'(NR)) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Round key bank: cipher key on load, one expanded key per round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else if (load) begin
      rk_q[0] <= key_in;
    end else if (wr && round_q <= 4'(NR)) begin
      rk_q[round_q] <= next_key;
    end
  end

  assign rd_key    = (rd_idx <= 4'(NR)) ? rk_q[rd_idx] : '0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign key_valid = valid_q;

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
Iterative AES-128 key expansion engine. It accepts a 128-bit cipher key, computes one round key per clock for rounds 1..10, and stores all 11 round keys in an internal register bank. The downstream AES round datapath reads keys by index through a random-access read port. It sits between key load and the encrypt/decrypt round pipeline, and wraps the single-round expansion function with sequencing, storage and a start/done handshake.

Parameters:
NR, 10, number of expansion rounds (fixed at 10 for AES-128; no other value supported)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request expansion of key_in; honoured only in IDLE
key_in  input  128  cipher key, FIPS-197 byte order (w0 = key_in[127:96])
busy  output  1  high while expansion is in progress
done  output  1  one-cycle pulse when round key 10 has been written
key_valid  output  1  high when all 11 stored round keys belong to the last accepted key
rd_idx  input  4  round-key index, 0..10
rd_key  output  128  round key rk[rd_idx]; combinational read

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on rst_n.
- Reset values: state=IDLE, busy=0, done=0, key_valid=0, round counter=0, all rk[0..10]=0.
- Reset asserted mid-expansion: abort the expansion and apply the reset values above. No done pulse is issued.
- FSM states: IDLE, EXPAND, FINISH.
- IDLE to EXPAND: on an edge where start=1.
  - At that edge: rk[0] <= key_in, round <= 1, busy <= 1, key_valid <= 0.
- EXPAND: at each edge, rk[round] <= f(rk[round-1], rcon(round)), then round <= round+1.
  - At the edge that writes rk[10]: state <= FINISH, busy <= 0, done <= 1, key_valid <= 1.
- FINISH to IDLE: unconditional after one cycle; done <= 0.
- Timing: start sampled at edge E0 gives busy high for cycles E0+1..E0+10, done high in cycle E0+11 only. Total latency is 11 cycles.
- start while busy, or while in FINISH: ignored; key_in is not sampled.
- start asserted continuously: a new expansion begins at the first IDLE edge, which means back-to-back runs occur every 12 cycles.
- New start with key_valid=1: key_valid drops at the start edge. Stale rk entries stay readable but are not valid.
- Expansion function f, with w0..w3 = rk[127:96], [95:64], [63:32], [31:0]:
  - t = SubWord(RotWord(w3)) ^ rcon, where RotWord(w) = {w[23:0], w[31:24]} and SubWord applies the AES S-box per byte.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2; result = {n0, n1, n2, n3}.
- rcon(round), for round 1..10, top byte only: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. Low 24 bits are zero.
- Read port: rd_key = rk[rd_idx] combinationally for rd_idx 0..10; rd_idx 11..15 returns 128'h0.
- Reads during expansion are legal. They return the current register contents.
- Only one f instance is used (4 S-boxes); the round counter selects the source and destination registers.

Decomposition:
- Shared package aes_pkg holds:
  - the AES S-box table constant;
  - the rcon table, indexed by round 1..10;
  - the constants NR=10 and NK_WORDS=4;
  - the FSM state enum.
- One sub-module, aes_key_round: purely combinational, taking prev_key[127:0] and round[3:0] and producing next_key[127:0]. It instantiates 4 S-box lookups from aes_pkg.
- aes_key_schedule holds the FSM, the counter, the rk bank and the read mux.

Test Plan:
- FIPS-197 App. A key 2b7e151628aed2a6abf7158809cf4f3c, pulse start -> done exactly 11 cycles later; rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6, rk0 equals key_in.
- All-zero key -> rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e; key_valid=1 after done.
- Key 000102030405060708090a0b0c0d0e0f -> rk10=13111d7fe3944a17f307a78b4d2b30c5; start pulsed again at cycles 3 and 7 of busy -> ignored, result unchanged, single done pulse.
- rst_n=0 at 5th busy cycle -> next cycle busy=0, done never pulses, key_valid=0, rd_key for every idx = 0; a following start completes normally.
- After a valid run, start with a new key -> key_valid falls at the start edge and returns at done; rd_idx=11..15 -> rd_key=0 at all times.
- start held high for 30 cycles -> expansions start at E0 and E0+12, done pulses at E0+11 and E0+23.
